// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder unit: default width and the
// legal width range, plus a helper used for the elaboration-time range check.
package adder_pkg;

    localparam int ADDER_WIDTH_DEF = 1;
    localparam int ADDER_WIDTH_MIN = 1;
    localparam int ADDER_WIDTH_MAX = 64;

    function automatic bit adder_width_ok(input int width);
        return (width >= ADDER_WIDTH_MIN) && (width <= ADDER_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder; the top module chains one per operand bit.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;

    assign prop = a ^ b;
    assign sum  = prop ^ cin;
    assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple-carry adder: {carry, sum} = a + b + c, one cycle
// latency, one operand set per cycle, outputs hold when no valid input arrives.
module full_adder_unit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);

    generate
        if (!adder_width_ok(WIDTH)) begin : g_width_check
            $error("full_adder_unit: WIDTH=%0d outside legal range %0d..%0d",
                   WIDTH, ADDER_WIDTH_MIN, ADDER_WIDTH_MAX);
        end
    endgenerate

    // chain[i] is the carry into bit i; chain[WIDTH] is the final carry-out.
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] sum_comb;

    assign chain[0] = c;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder_bit u_bit (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (chain[i]),
                .sum  (sum_comb[i]),
                .cout (chain[i+1])
            );
        end
    endgenerate

    // Result registers only load on in_valid, so unknown operands presented
    // while idle never reach sum/carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_comb;
                carry <= chain[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed bench for full_adder_unit at WIDTH=1, 8 and 32 with hand-computed
// expectations; prints one summary line.
module tb_full_adder_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       v1, c1, k1, ov1;
    logic [0:0] a1, b1, s1;

    logic       v8, c8, k8, ov8;
    logic [7:0] a8, b8, s8;

    logic        v32, c32, k32, ov32;
    logic [31:0] a32, b32, s32;

    int errors = 0;
    int checks = 0;

    full_adder_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
        .sum(s1), .carry(k1), .out_valid(ov1)
    );

    full_adder_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
        .sum(s8), .carry(k8), .out_valid(ov8)
    );

    full_adder_unit #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(v32), .a(a32), .b(b32), .c(c32),
        .sum(s32), .carry(k32), .out_valid(ov32)
    );

    // Advance past the next rising edge; outputs are sampled here and the
    // next inputs are driven here, well away from either edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        v8 = 0; a8 = 0; b8 = 0; c8 = 0;
        v32 = 0; a32 = 0; b32 = 0; c32 = 0;
        tick();
        tick();
        checks++;
        if ({k1, s1, ov1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_w1: got carry=%b sum=%b out_valid=%b, want 0 0 0", k1, s1, ov1);
        end
        checks++;
        if ({k8, s8, ov8} !== 10'd0) begin
            errors++;
            $display("FAIL reset_w8: got carry=%b sum=%h out_valid=%b, want 0 00 0", k8, s8, ov8);
        end
        checks++;
        if ({k32, s32, ov32} !== 34'd0) begin
            errors++;
            $display("FAIL reset_w32: got carry=%b sum=%h out_valid=%b, want 0 0 0", k32, s32, ov32);
        end
        rst = 1'b0;
    endtask

    task automatic test_truth_table_w1;
        logic [1:0] expv [8];
        logic [2:0] abc;
        expv = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            abc = i[2:0];
            a1  = abc[2];
            b1  = abc[1];
            c1  = abc[0];
            v1  = 1'b1;
            tick();
            checks++;
            if ({k1, s1} !== expv[i] || ov1 !== 1'b1) begin
                errors++;
                $display("FAIL truth_w1[%0d]: got carry,sum=%b%b out_valid=%b, want %b 1",
                         i, k1, s1, ov1, expv[i]);
            end
        end
        v1 = 1'b0;
        tick();
        checks++;
        if (ov1 !== 1'b0 || {k1, s1} !== 2'b11) begin
            errors++;
            $display("FAIL idle_w1: got carry,sum=%b%b out_valid=%b, want 11 0", k1, s1, ov1);
        end
    endtask

    task automatic test_boundaries;
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; c32 = 1'b1; v32 = 1'b1;
        tick();
        checks++;
        if (s8 !== 8'h00 || k8 !== 1'b1 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_w8: got sum=%h carry=%b out_valid=%b, want 00 1 1", s8, k8, ov8);
        end
        checks++;
        if (s32 !== 32'hFFFF_FFFF || k32 !== 1'b1) begin
            errors++;
            $display("FAIL allones_w32: got sum=%h carry=%b, want ffffffff 1", s32, k32);
        end
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; c32 = 1'b1;
        tick();
        checks++;
        if (s8 !== 8'hFF || k8 !== 1'b1 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL allones_w8: got sum=%h carry=%b out_valid=%b, want ff 1 1", s8, k8, ov8);
        end
        checks++;
        if (s32 !== 32'h0 || k32 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_w32: got sum=%h carry=%b, want 00000000 1", s32, k32);
        end
        a8 = 8'h80; b8 = 8'h7F; c8 = 1'b0;
        v32 = 1'b0;
        tick();
        checks++;
        if (s8 !== 8'hFF || k8 !== 1'b0) begin
            errors++;
            $display("FAIL nocarry_w8: got sum=%h carry=%b, want ff 0", s8, k8);
        end
        v8 = 1'b0;
        tick();
    endtask

    task automatic test_hold;
        int pulses;
        a8 = 8'd3; b8 = 8'd4; c8 = 1'b0; v8 = 1'b1;
        tick();
        pulses = ov8 ? 1 : 0;
        checks++;
        if (s8 !== 8'd7 || k8 !== 1'b0 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: got sum=%0d carry=%b out_valid=%b, want 7 0 1", s8, k8, ov8);
        end
        v8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom);
            b8 = (i == 2) ? 8'hxx : 8'($urandom);
            c8 = (i == 3) ? 1'bx : 1'($urandom);
            tick();
            if (ov8) pulses++;
            checks++;
            if (s8 !== 8'd7 || k8 !== 1'b0 || ov8 !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got sum=%0d carry=%b out_valid=%b, want 7 0 0",
                         i, s8, k8, ov8);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL hold_pulses: got %0d out_valid pulses, want 1", pulses);
        end
        c8 = 1'b0;
    endtask

    task automatic test_reset_during_valid;
        a8 = 8'hAA; b8 = 8'hAA; c8 = 1'b0; v8 = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s8 !== 8'h00 || k8 !== 1'b0 || ov8 !== 1'b0) begin
                errors++;
                $display("FAIL rst_valid[%0d]: got sum=%h carry=%b out_valid=%b, want 00 0 0",
                         i, s8, k8, ov8);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (s8 !== 8'h54 || k8 !== 1'b1 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: got sum=%h carry=%b out_valid=%b, want 54 1 1", s8, k8, ov8);
        end
        v8 = 1'b0;
        tick();
        checks++;
        if (ov8 !== 1'b0 || s8 !== 8'h54) begin
            errors++;
            $display("FAIL rst_release_idle: got sum=%h out_valid=%b, want 54 0", s8, ov8);
        end
    endtask

    task automatic test_reset_after_valid;
        a8 = 8'd10; b8 = 8'd20; c8 = 1'b1; v8 = 1'b1;
        tick();
        checks++;
        if (s8 !== 8'd31 || k8 !== 1'b0 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_result: got sum=%0d carry=%b out_valid=%b, want 31 0 1", s8, k8, ov8);
        end
        v8 = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (s8 !== 8'd0 || k8 !== 1'b0 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_clear: got sum=%0d carry=%b out_valid=%b, want 0 0 0", s8, k8, ov8);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [32:0] expv;
        int bad;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            a32 = $urandom;
            b32 = $urandom;
            c32 = 1'($urandom_range(0, 1));
            v32 = 1'b1;
            expv = {1'b0, a32} + {1'b0, b32} + {32'd0, c32};
            tick();
            checks++;
            if ({k32, s32} !== expv || ov32 !== 1'b1) begin
                errors++;
                if (bad < 10)
                    $display("FAIL stream[%0d]: got carry,sum=%h out_valid=%b, want %h 1",
                             n, {k32, s32}, ov32, expv);
                bad++;
            end
        end
        v32 = 1'b0;
        tick();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got out_valid=%b, want 0", ov32);
        end
    endtask

    initial begin
        test_reset();
        test_truth_table_w1();
        test_boundaries();
        test_hold();
        test_reset_during_valid();
        test_reset_after_valid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
